// File: rtl/jtag_tap_bsr_if.sv
// jtag_tap_bsr_if: serial JTAG port bundle (TMS/TDI in, TDO/TDO_en and
// tap_state out). master = tester side, slave = TAP side.
interface jtag_tap_bsr_if;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_en;
  logic [3:0] tap_state;

  modport master (
    output TMS, TDI,
    input  TDO, TDO_en, tap_state
  );

  modport slave (
    input  TMS, TDI,
    output TDO, TDO_en, tap_state
  );
endinterface

// File: rtl/jtag_tap_bsr.sv
// jtag_tap_bsr: 16-state TAP with IR, bypass, optional IDCODE and a
// boundary-scan register of N_IN input cells and N_OUT output cells.
// Ports: TCK, reset (sync, active-high), jtag (TMS/TDI/TDO/TDO_en/
// tap_state), pin_in->core_in, core_out->pin_out.
// Macro JTAG_IDCODE_EN adds the 32-bit ID register; without it the
// reset/TLR instruction is BYPASS.
module jtag_tap_bsr #(
  parameter int          IR_WIDTH   = 4,
  parameter int          N_IN       = 9,
  parameter int          N_OUT      = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B
) (
  input  logic             TCK,
  input  logic             reset,
  jtag_tap_bsr_if.slave    jtag,
  input  logic [N_IN-1:0]  pin_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pin_out
);

  localparam int N = N_IN + N_OUT;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_IR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_IR = OP_BYPASS;
`endif

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,
    SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,
    PS_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,
    CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PS_IR  = 4'd13,
    EX2_IR = 4'd14, UPD_IR = 4'd15
  } state_t;

  state_t state;

  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_act;
  logic [N-1:0]        bsr_sr;
  logic [N-1:0]        bsr_upd;
  logic                byp;
  logic                sel_bsr;
  logic                sel_id;
  logic                id_lsb;
  logic                tms;

  assign tms = jtag.TMS;

  always_ff @(posedge TCK) begin
    if (reset) begin
      state <= TLR;
    end else begin
      unique case (state)
        TLR:    state <= tms ? TLR    : RTI;
        RTI:    state <= tms ? SEL_DR : RTI;
        SEL_DR: state <= tms ? SEL_IR : CAP_DR;
        CAP_DR: state <= tms ? EX1_DR : SH_DR;
        SH_DR:  state <= tms ? EX1_DR : SH_DR;
        EX1_DR: state <= tms ? UPD_DR : PS_DR;
        PS_DR:  state <= tms ? EX2_DR : PS_DR;
        EX2_DR: state <= tms ? UPD_DR : SH_DR;
        UPD_DR: state <= tms ? SEL_DR : RTI;
        SEL_IR: state <= tms ? TLR    : CAP_IR;
        CAP_IR: state <= tms ? EX1_IR : SH_IR;
        SH_IR:  state <= tms ? EX1_IR : SH_IR;
        EX1_IR: state <= tms ? UPD_IR : PS_IR;
        PS_IR:  state <= tms ? EX2_IR : PS_IR;
        EX2_IR: state <= tms ? UPD_IR : SH_IR;
        UPD_IR: state <= tms ? SEL_DR : RTI;
      endcase
    end
  end

  assign jtag.tap_state = state;

  // TLR forces the reset instruction as soon as the state is entered,
  // not one edge later.
  assign ir_act = (state == TLR) ? RST_IR : ir_q;

  always_comb begin
    sel_bsr = 1'b0;
    sel_id  = 1'b0;
    unique case (1'b1)
      (ir_act == OP_EXTEST),
      (ir_act == OP_SAMPLE),
      (ir_act == OP_INTEST): sel_bsr = 1'b1;
`ifdef JTAG_IDCODE_EN
      (ir_act == OP_IDCODE): sel_id = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge TCK) begin
    if (reset) begin
      id_sr <= '0;
    end else if (sel_id) begin
      if (state == CAP_DR) id_sr <= IDCODE_VAL;
      else if (state == SH_DR) id_sr <= {jtag.TDI, id_sr[31:1]};
    end
  end

  assign id_lsb = id_sr[0];
`else
  logic unused_idcode;
  assign unused_idcode = ^{IDCODE_VAL, OP_IDCODE, sel_id};
  assign id_lsb        = 1'b0;
`endif

  always_ff @(posedge TCK) begin
    if (reset) begin
      ir_sr   <= '0;
      ir_q    <= RST_IR;
      bsr_sr  <= '0;
      bsr_upd <= '0;
      byp     <= 1'b0;
    end else begin
      case (state)
        TLR:    ir_q  <= RST_IR;
        CAP_IR: ir_sr <= IR_WIDTH'(1);
        SH_IR:  ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir_q  <= ir_sr;
        CAP_DR: begin
          if (sel_bsr) bsr_sr <= {core_out, pin_in};
          byp <= 1'b0;
        end
        SH_DR: begin
          if (sel_bsr) bsr_sr <= {jtag.TDI, bsr_sr[N-1:1]};
          byp <= jtag.TDI;
        end
        UPD_DR: if (sel_bsr) bsr_upd <= bsr_sr;
        default: ;
      endcase
    end
  end

  always_comb begin
    jtag.TDO = 1'b0;
    if (state == SH_IR) begin
      jtag.TDO = ir_sr[0];
    end else if (state == SH_DR) begin
      if (sel_bsr)     jtag.TDO = bsr_sr[0];
      else if (sel_id) jtag.TDO = id_lsb;
      else             jtag.TDO = byp;
    end
  end

  assign jtag.TDO_en = (state == SH_DR) || (state == SH_IR);

  assign core_in = (ir_act == OP_INTEST) ? bsr_upd[N_IN-1:0] : pin_in;
  assign pin_out = (ir_act == OP_EXTEST) ? bsr_upd[N-1:N_IN] : core_out;

endmodule
